input_debounce: RTL and testbench
=================================

# input_debounce

Synchronises and debounces the raw board push-buttons and DIP switches before they reach the HPS-visible PIO inputs of the SoC system. Each bit passes through a 2-flop synchroniser, then a per-bit stability counter. A bit's clean output changes only after the synchronised input has differed from it for CNT_MAX consecutive cycles. Single-cycle rise/fall event pulses and an aggregate event flag are provided for fabric-side logic.

## Interface
- WIDTH, 6: number of debounced bits. Bits [1:0] are buttons (feed button_pio_export). Bits [5:2] are DIP switches (feed dipsw_pio_export).
- CNT_MAX, 1000000: consecutive differing cycles required to accept a change (20 ms at 50 MHz). Legal range ≥ 2.
- RESET_VAL, {WIDTH{1'b1}}: reset value of synchroniser flops and clean outputs (buttons idle high).

Ports:
- clk_clk  input  1  system clock, 50 MHz.
- reset_reset_n  input  1  reset; asynchronous, active-low.
- raw_in  input  WIDTH  asynchronous pin levels.
- clean_out  output  WIDTH  debounced levels; reset RESET_VAL.
- rise_pulse  output  WIDTH  one-cycle pulse when a clean bit goes 0→1; reset 0.
- fall_pulse  output  WIDTH  one-cycle pulse when a clean bit goes 1→0; reset 0.
- any_event  output  1  registered OR of rise_pulse|fall_pulse, one cycle late; reset 0.

## Operation
- Per bit, sync1 <= raw_in and sync2 <= sync1, both reset to RESET_VAL.
- cnt, width $clog2(CNT_MAX), resets to 0.
- On each edge:
  - If sync2 == clean: cnt <= 0.
  - Else if cnt == CNT_MAX-1: clean <= sync2, cnt <= 0, and rise_pulse or fall_pulse <= 1 according to the new value.
  - Otherwise: cnt <= cnt+1.
- rise_pulse and fall_pulse are 0 on every edge that does not accept a change.
- Glitch shorter than CNT_MAX cycles: cnt clears on return, clean_out is unchanged, no pulse.
- Input toggling during the count: any cycle with sync2 == clean restarts the count from 0.
- Bits are fully independent. Simultaneous acceptance on several bits yields simultaneous pulses and a single any_event cycle.
- Reset asserted mid-count: all state returns to its reset values immediately. No pulse is emitted on reset release.
- cnt never exceeds CNT_MAX-1, so it cannot wrap.

## Timing
- Raw edge sampled at clock edge k: sync2 updates at edge k+1. The first differing count happens at edge k+2. clean_out and the pulse update at edge k+1+CNT_MAX.
- Total latency is CNT_MAX+1 cycles from the sampling edge.
- Pulses are high for exactly one cycle, aligned with the clean_out change.
- any_event is asserted one cycle after the pulse, for one cycle per acceptance edge.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Sub-module debounce_bit holds sync1, sync2, cnt, clean, rise and fall for one bit. input_debounce instantiates WIDTH copies with a generate loop and adds the any_event register.
- Shared package soc_io_pkg holds:
  - DEBOUNCE_CNT_20MS = 1000000
  - BTN_LSB = 0, BTN_W = 2
  - DIPSW_LSB = 2, DIPSW_W = 4
- The top level slices clean_out into the button and DIP-switch PIO inputs.

## Test plan
Bench uses CNT_MAX=4 and WIDTH=6.
1. Reset values: hold reset with raw_in=6'h00 → clean_out=6'h3F, pulses 0, any_event 0. Release reset → clean_out falls after 5 cycles with fall_pulse=6'h3F for one cycle, then any_event=1 for one cycle.
2. Clean press: from a settled 6'h3F, drive raw_in[0]=0 at edge k → clean_out[0]=0 and fall_pulse=6'h01 exactly at edge k+5, one cycle only. Release → rise_pulse=6'h01 five cycles after the sampling edge.
3. Glitch rejection: raw_in[1] low for 3 cycles then high → clean_out stays 6'h3F and no pulses. Low for 4 cycles → accepted.
4. Bounce: raw_in[2] toggles 1,0,0,1,0,0,0,0,… → one fall_pulse only, 5 cycles after the last 1→0 sample.
5. Simultaneous bits: raw_in 6'h3F→6'h30 on one edge → fall_pulse=6'h0F on a single cycle and a single any_event cycle.
6. Reset mid-count: raw_in[3]=0 for 2 cycles, then assert reset → clean_out=6'h3F, cnt=0, no pulse. After release with raw_in=6'h3F → no events.

Source files
------------

// File: rtl/soc_io_pkg.sv
// soc_io_pkg: shared SoC I/O constants for the button and DIP-switch PIO slices.
package soc_io_pkg;
  localparam int DEBOUNCE_CNT_20MS = 1000000;
  localparam int BTN_LSB = 0;
  localparam int BTN_W = 2;
  localparam int DIPSW_LSB = 2;
  localparam int DIPSW_W = 4;
  localparam int IO_W = BTN_W + DIPSW_W;
endpackage

// File: rtl/input_debounce_bit.sv
// debounce_bit: 2-flop synchroniser plus stability counter for one raw input bit.
module debounce_bit
  import soc_io_pkg::*;
#(
  parameter int   CNT_MAX = DEBOUNCE_CNT_20MS,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_clean;
  logic          r_rise;
  logic          r_fall;
  logic          w_diff;
  logic          w_accept;
  assign w_diff   = r_sync2 != r_clean;
  assign w_accept = w_diff && (r_cnt == LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
      r_cnt   <= '0;
      r_clean <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_cnt   <= (!w_diff || w_accept) ? '0 : r_cnt + 1'b1;
      r_clean <= w_accept ? r_sync2 : r_clean;
      r_rise  <= w_accept && r_sync2;
      r_fall  <= w_accept && !r_sync2;
    end
  end
  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/input_debounce.sv
// input_debounce: per-bit debounce of board buttons/DIP switches with edge pulses and
// an aggregate event flag; clean levels are also sliced out for the PIO inputs.
module input_debounce
  import soc_io_pkg::*;
#(
  parameter int               WIDTH     = IO_W,
  parameter int               CNT_MAX   = DEBOUNCE_CNT_20MS,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [WIDTH-1:0]   raw_in,
  output logic [WIDTH-1:0]   clean_out,
  output logic [WIDTH-1:0]   rise_pulse,
  output logic [WIDTH-1:0]   fall_pulse,
  output logic               any_event,
  output logic [BTN_W-1:0]   o_button_pio,
  output logic [DIPSW_W-1:0] o_dipsw_pio
);
  logic r_any;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_MAX(CNT_MAX),
      .RST_VAL(RESET_VAL[i])
    ) u_bit (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .i_raw  (raw_in[i]),
      .o_clean(clean_out[i]),
      .o_rise (rise_pulse[i]),
      .o_fall (fall_pulse[i])
    );
  end
  // Simultaneous acceptances on several bits collapse into one event cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_any <= 1'b0;
    else r_any <= |(rise_pulse | fall_pulse);
  end
  assign any_event    = r_any;
  assign o_button_pio = clean_out[BTN_LSB +: BTN_W];
  assign o_dipsw_pio  = clean_out[DIPSW_LSB +: DIPSW_W];
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: table-driven scoreboard bench for input_debounce with CNT_MAX=4.
module tb_input_debounce;
  typedef struct {
    logic [5:0] raw;
    logic [5:0] clean;
    logic [5:0] rise;
    logic [5:0] fall;
    logic       any;
  } vec_t;
  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [5:0] raw_in = 6'h00;
  logic [5:0] clean_out, rise_pulse, fall_pulse;
  logic       any_event;
  logic [1:0] o_button_pio;
  logic [3:0] o_dipsw_pio;
  int passed = 0;
  int total = 0;
  vec_t tbl[$];
  vec_t sb[$];
  input_debounce #(.WIDTH(6), .CNT_MAX(4), .RESET_VAL(6'h3F)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .raw_in       (raw_in),
    .clean_out    (clean_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .any_event    (any_event),
    .o_button_pio (o_button_pio),
    .o_dipsw_pio  (o_dipsw_pio)
  );
  always #5 clk_clk = ~clk_clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", n, act, exp);
  endtask
  task automatic add(input logic [5:0] r, input logic [5:0] c, input logic [5:0] ri,
                     input logic [5:0] fa, input logic an);
    vec_t v;
    v.raw = r; v.clean = c; v.rise = ri; v.fall = fa; v.any = an;
    tbl.push_back(v);
  endtask
  task automatic quiet(input logic [5:0] r, input logic [5:0] c, input int n);
    for (int i = 0; i < n; i++) add(r, c, 6'h00, 6'h00, 1'b0);
  endtask
  // Change sampled at row k is accepted at row k+5; any_event follows at k+6.
  task automatic toggle(input logic [5:0] r, input logic [5:0] co, input logic [5:0] cn);
    quiet(r, co, 5);
    add(r, cn, cn & ~co, co & ~cn, 1'b0);
    add(r, cn, 6'h00, 6'h00, 1'b1);
    add(r, cn, 6'h00, 6'h00, 1'b0);
  endtask
  task automatic outputs_idle(input string n, input logic [5:0] c);
    chk({n, " clean"}, 32'(clean_out), 32'(c));
    chk({n, " rise"}, 32'(rise_pulse), 32'h0);
    chk({n, " fall"}, 32'(fall_pulse), 32'h0);
    chk({n, " any"}, 32'(any_event), 32'h0);
  endtask
  initial begin
    vec_t e;
    toggle(6'h00, 6'h3F, 6'h00);
    toggle(6'h3F, 6'h00, 6'h3F);
    toggle(6'h3E, 6'h3F, 6'h3E);
    toggle(6'h3F, 6'h3E, 6'h3F);
    quiet(6'h3D, 6'h3F, 3);
    quiet(6'h3F, 6'h3F, 6);
    quiet(6'h3D, 6'h3F, 4);
    add(6'h3F, 6'h3F, 6'h00, 6'h00, 1'b0);
    add(6'h3F, 6'h3D, 6'h00, 6'h02, 1'b0);
    add(6'h3F, 6'h3D, 6'h00, 6'h00, 1'b1);
    quiet(6'h3F, 6'h3D, 2);
    add(6'h3F, 6'h3F, 6'h02, 6'h00, 1'b0);
    add(6'h3F, 6'h3F, 6'h00, 6'h00, 1'b1);
    quiet(6'h3F, 6'h3F, 4);
    add(6'h3F, 6'h3F, 6'h00, 6'h00, 1'b0);
    add(6'h3B, 6'h3F, 6'h00, 6'h00, 1'b0);
    add(6'h3B, 6'h3F, 6'h00, 6'h00, 1'b0);
    add(6'h3F, 6'h3F, 6'h00, 6'h00, 1'b0);
    toggle(6'h3B, 6'h3F, 6'h3B);
    toggle(6'h3F, 6'h3B, 6'h3F);
    toggle(6'h30, 6'h3F, 6'h30);
    toggle(6'h3F, 6'h30, 6'h3F);
    repeat (3) @(posedge clk_clk);
    #1 outputs_idle("reset_hold", 6'h3F);
    @(negedge clk_clk) reset_reset_n = 1'b1;
    foreach (tbl[i]) begin
      raw_in = tbl[i].raw;
      sb.push_back(tbl[i]);
      @(posedge clk_clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d clean", i), 32'(clean_out), 32'(e.clean));
      chk($sformatf("row%0d rise", i), 32'(rise_pulse), 32'(e.rise));
      chk($sformatf("row%0d fall", i), 32'(fall_pulse), 32'(e.fall));
      chk($sformatf("row%0d any", i), 32'(any_event), 32'(e.any));
      chk($sformatf("row%0d btn", i), 32'(o_button_pio), 32'(e.clean[1:0]));
      chk($sformatf("row%0d dipsw", i), 32'(o_dipsw_pio), 32'(e.clean[5:2]));
    end
    raw_in = 6'h37;
    repeat (4) @(posedge clk_clk);
    #1 chk("midcount cnt", 32'(dut.g_bit[3].u_bit.r_cnt), 32'd2);
    reset_reset_n = 1'b0;
    #1 outputs_idle("midreset", 6'h3F);
    chk("midreset cnt", 32'(dut.g_bit[3].u_bit.r_cnt), 32'd0);
    raw_in = 6'h3F;
    @(negedge clk_clk) reset_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_clk);
      #1 outputs_idle($sformatf("post_reset%0d", i), 6'h3F);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
